// File: rtl/alu_arbiter.sv
// Purpose: round-robin (or fixed priority with ARB_FIXED_PRIORITY_EN) arbiter sharing one ALU among four requesters.
// Latency: grant/alu_start one cycle after req is sampled in IDLE; done ALU_LATENCY+2 cycles after the sample.
// Backpressure: req is a level; a request waits in IDLE until it wins and is ignored while an operation is in flight.
module alu_arbiter #(
    parameter int ALU_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       alu_start,
    output logic [3:0] done,
    output logic       busy
);

    if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
        $error("alu_arbiter: ALU_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [1:0] winner;
    logic [3:0] sel_oh;

`ifdef ARB_FIXED_PRIORITY_EN
    // Lowest index wins; scanning downward lets the lowest set bit overwrite.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) winner = 2'(i);
        end
    end
`else
    logic [1:0] ptr;

    // Scan offsets 4..1 from the pointer so the smallest offset (ptr+1) wins last;
    // offset 4 wraps onto ptr itself, giving the last winner lowest priority.
    always_comb begin
        logic [1:0] idx;
        idx    = 2'd0;
        winner = ptr;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) winner = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd3;
        end else if (state == S_DONE) begin
            ptr <= sel;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // sel only moves on IDLE->ISSUE, so it stays stable for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= 2'd0;
            wait_cnt <= 4'd0;
        end else begin
            if (state == S_IDLE && |req) begin
                sel <= winner;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    assign sel_oh = 4'b0001 << sel;

    always_comb begin
        grant     = 4'b0000;
        done      = 4'b0000;
        alu_start = 1'b0;
        busy      = 1'b0;
        case (state)
            S_ISSUE: begin
                grant     = sel_oh;
                alu_start = 1'b1;
                busy      = 1'b1;
            end
            S_WAIT: begin
                grant = sel_oh;
                busy  = 1'b1;
            end
            S_DONE: begin
                grant = sel_oh;
                done  = sel_oh;
                busy  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a done scoreboard; default ALU_LATENCY of 2.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       alu_start;
    logic [3:0] done;
    logic       busy;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int exp_q[$];

    alu_arbiter #(.ALU_LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .sel       (sel),
        .alu_start (alu_start),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected requester.
    always @(negedge clk) begin
        if (!rst && done != 4'b0000) begin
            int e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {28'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_onehot", {28'd0, done}, 32'd1 << e);
                chk("done_grant", {28'd0, grant}, {28'd0, done});
            end
        end
    end

    task automatic wait_start(output int start_cyc);
        bit seen;
        seen = 1'b0;
        start_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (alu_start) begin
                seen = 1'b1;
                start_cyc = cyc;
                break;
            end
        end
        if (!seen) chk("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_op(input int idx, output int start_cyc);
        exp_q.push_back(idx);
        wait_start(start_cyc);
        chk("sel", {30'd0, sel}, idx);
        chk("grant", {28'd0, grant}, 32'd1 << idx);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int prev;
        int d0;
        int order [5] = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_start", {31'd0, alu_start}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, exact cycle-by-cycle latency.
        req = 4'b0001;
        exp_q.push_back(0);
        @(negedge clk);
        chk("t1_start", {31'd0, alu_start}, 32'd1);
        chk("t1_grant", {28'd0, grant}, 32'd1);
        chk("t1_sel", {30'd0, sel}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_start_pulse", {31'd0, alu_start}, 32'd0);
        chk("t1_grant_held", {28'd0, grant}, 32'd1);
        chk("t1_no_early_done", {28'd0, done}, 32'd0);
        @(negedge clk);
        chk("t1_no_early_done2", {28'd0, done}, 32'd0);
        @(negedge clk);
        chk("t1_done", {28'd0, done}, 32'd1);
        chk("t1_busy_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_idle_done", {28'd0, done}, 32'd0);

`ifndef ARB_FIXED_PRIORITY_EN
        // All four requesting: rotation from reset pointer, 5-cycle spacing.
        reset_pulse();
        req  = 4'b1111;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            expect_op(order[i], st);
            if (prev >= 0) chk("rr_gap", st - prev, 32'd5);
            prev = st;
        end
        req = 4'b0010;
        expect_op(1, st);
        req = 4'b1010;
        expect_op(3, st);
        expect_op(1, st);
        expect_op(3, st);
        req = 4'b0000;
        wait_idle();
        chk("rr_queue_empty", exp_q.size(), 32'd0);
`else
        reset_pulse();
        req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            expect_op(1, st);
        end
        req = 4'b0000;
        wait_idle();
        chk("fp_queue_empty", exp_q.size(), 32'd0);
`endif

        // Request dropped during WAIT still completes.
        @(negedge clk);
        req = 4'b0100;
        expect_op(2, st);
        @(negedge clk);
        req = 4'b0000;
        wait_idle();
        chk("drop_busy", {31'd0, busy}, 32'd0);
        chk("drop_queue_empty", exp_q.size(), 32'd0);

        // Reset in WAIT: outputs clear at once and the result is discarded.
        req = 4'b0001;
        wait_start(st);
        @(negedge clk);
        #2;
        rst = 1'b1;
        req = 4'b0000;
        #1;
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_sel", {30'd0, sel}, 32'd0);
        chk("mid_rst_start", {31'd0, alu_start}, 32'd0);
        chk("mid_rst_done", {28'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        req = 4'b1000;
        expect_op(3, st);
        req = 4'b0000;
        wait_idle();
        chk("post_rst_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one luftALU datapath between four requesters. It picks one pending request and drives the select of the operand `four_input_mux` in front of the ALU. It issues a start pulse, waits a fixed ALU latency, then returns a one-cycle done pulse to the granted requester. It sits between the requester ports and the operand muxes, and sequences every ALU operation.

## Interface

Parameters:
- `ALU_LATENCY`, default 2: cycles from `alu_start` to a valid ALU result. Legal range 1..15.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per requester, bit i = requester i.
- `grant` output 4: one-hot grant, or all-zero when idle.
- `sel` output 2: select for the operand `four_input_mux` (0→a, 1→b, 2→c, 3→d); equals the index of the granted requester.
- `alu_start` output 1: one-cycle pulse launching the ALU operation.
- `done` output 4: one-cycle pulse to the granted requester when the result is valid.
- `busy` output 1: high in every state except IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If `req` ≠ 0: latch the winner index into `sel`, go to ISSUE.
  - If `req` = 0: stay in IDLE.
- ISSUE:
  - `grant[sel]`=1 and `alu_start`=1 for exactly this cycle.
  - Load the wait counter with `ALU_LATENCY`-1 and go to WAIT.
- WAIT:
  - `grant` is held.
  - Counter decrements each cycle; at 0, go to DONE.
- DONE:
  - `done[sel]`=1 and `grant` is held for this cycle.
  - Update the round-robin pointer to `sel`, then go to IDLE.
- Round-robin winner: the first set bit of `req` scanning from (pointer+1) mod 4 upward, wrapping 3→0.
- Pointer reset value is 3, so requester 0 wins first after reset.
- Once ISSUE is entered, `req` changes are ignored until IDLE.
  - Dropping `req` mid-operation does not abort it; `done` still pulses.
  - A requester that keeps `req` high after `done` re-competes in IDLE at lowest priority relative to the others.
- Only one operation is in flight at a time. `sel` changes only on the IDLE→ISSUE transition.
- Reset mid-operation: state returns to IDLE, pointer returns to 3, all outputs go to reset values immediately. The in-flight result is discarded and no `done` pulses.

## Timing

- Reset values: `grant`=0, `sel`=0, `alu_start`=0, `done`=0, `busy`=0, state IDLE, counter 0, pointer 3.
- Request sampled in IDLE at edge N:
  - `alu_start` and `grant` high during cycle N+1 (ISSUE).
  - WAIT occupies cycles N+2 .. N+1+`ALU_LATENCY`.
  - `done` high in cycle N+2+`ALU_LATENCY`.
- Total occupancy is `ALU_LATENCY`+3 cycles per operation, including one IDLE bubble between back-to-back grants.
- `ALU_LATENCY`=1: exactly one WAIT cycle.
- All outputs are registered or decoded from registered state only; there is no combinational path from `req` to any output.
- `busy` is high from ISSUE through DONE inclusive.

## Configuration

- `ARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, requester 0 highest through requester 3 lowest. The pointer register is removed and the winner ignores history.
  - Undefined (default): round-robin as described above.
  - FSM, timing and all ports are identical in both builds.

## Test plan

- Reset, then `req`=4'b0001 held:
  - `alu_start` and `grant`=0001 one cycle after the sample, `sel`=0.
  - `done`=0001 at cycle `ALU_LATENCY`+2 after the sample (4 with default latency).
- `req`=4'b1111 held continuously, default build:
  - Grant order 0,1,2,3,0.
  - Successive `alu_start` pulses 5 cycles apart.
- `req`=4'b1010 after the pointer rests at 1: grant goes to 3, then 1, then 3.
- `req`=4'b0100, dropped to 0 during WAIT:
  - Operation completes and `done`=0100 pulses.
  - FSM returns to IDLE with `busy`=0.
- `rst` asserted during WAIT:
  - All outputs are 0 at once and no `done` pulses.
  - After release, `req`=4'b1000 is granted with `sel`=3.
- `ARB_FIXED_PRIORITY_EN` defined, `req`=4'b0110 held: every grant goes to requester 1, and requester 2 is never granted.
